// File: rtl/sr_bank.sv
// sr_bank: parametrised bank of WIDTH clocked set/reset flip-flops.
// Simultaneous set and reset on a channel is resolved by CONFLICT_MODE
// (0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle, >3 behaves as hold).
// EDGE_MODE 1 makes only rising edges of s/r act, judged against the
// previous cycle's inputs.
// Optional feature macro: SR_BANK_CONFLICT_CNT_EN adds the saturating
// conflict_cnt output. Without it the port and counter do not exist.
module sr_bank #(
    parameter int               WIDTH         = 8,
    parameter int               CONFLICT_MODE = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
    parameter int               EDGE_MODE     = 0,
    parameter int               CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] conflict,
`ifdef SR_BANK_CONFLICT_CNT_EN
    output logic [CNT_W-1:0] conflict_cnt,
`endif
    output logic [WIDTH-1:0] err_sticky
);

    // Out-of-range parameters are caught at elaboration.
    if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1) begin : g_param_check
        $error("sr_bank: WIDTH must be 1..64 and CNT_W at least 1");
    end

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_s_prev;
    logic [WIDTH-1:0] r_r_prev;
    logic [WIDTH-1:0] r_conflict;
    logic [WIDTH-1:0] r_err_sticky;

    logic [WIDTH-1:0] w_s_eff;
    logic [WIDTH-1:0] w_r_eff;
    logic [WIDTH-1:0] w_both;
    logic [WIDTH-1:0] w_conf_val;
    logic [WIDTH-1:0] w_q_nxt;

    // Effective requests: raw levels, or rising edges against last cycle.
    always_comb begin
        w_s_eff = s;
        w_r_eff = r;
        if (EDGE_MODE == 1) begin
            w_s_eff = s & ~r_s_prev;
            w_r_eff = r & ~r_r_prev;
        end
        w_both = w_s_eff & w_r_eff;
    end

    // Conflict resolution value and next state. Written as bitwise logic
    // so an X on a channel's s/r propagates to that channel's q only.
    always_comb begin
        case (CONFLICT_MODE)
            1:       w_conf_val = '1;
            2:       w_conf_val = '0;
            3:       w_conf_val = ~r_q;
            default: w_conf_val = r_q;
        endcase
        w_q_nxt = (w_s_eff & ~w_r_eff)
                | (~w_s_eff & ~w_r_eff & r_q)
                | (w_both & w_conf_val);
    end

    // Latch state, edge history, conflict pulse and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q          <= RESET_VALUE;
            r_s_prev     <= '0;
            r_r_prev     <= '0;
            r_conflict   <= '0;
            r_err_sticky <= '0;
        end else begin
            r_q          <= w_q_nxt;
            r_s_prev     <= s;
            r_r_prev     <= r;
            r_conflict   <= w_both;
            // A new conflict outranks a simultaneous clear.
            r_err_sticky <= (r_err_sticky & ~{WIDTH{clr_err}}) | w_both;
        end
    end

    assign q          = r_q;
    assign q_bar      = ~r_q;
    assign conflict   = r_conflict;
    assign err_sticky = r_err_sticky;

`ifdef SR_BANK_CONFLICT_CNT_EN
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       w_pop;
    logic [CNT_W-1:0] w_base;
    logic [CNT_W+7:0] w_sum;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Popcount of this cycle's conflicts, added to the count (or to zero
    // on clr_err) in a wide sum and clamped at the all-ones maximum.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + {6'd0, w_both[i]};
        end
        w_base = clr_err ? '0 : r_cnt;
        w_sum  = {8'd0, w_base} + {{(CNT_W + 1){1'b0}}, w_pop};
        if (w_sum > {8'd0, {CNT_W{1'b1}}}) begin
            w_cnt_nxt = {CNT_W{1'b1}};
        end else begin
            w_cnt_nxt = w_sum[CNT_W-1:0];
        end
    end

    // Saturating conflict counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign conflict_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_sr_bank.sv
// tb_sr_bank: four level-mode instances (one per conflict mode, reset value
// 8'hA5, 4-bit counter) share one stimulus stream driven from a vector
// table; one edge-mode instance gets its own inputs for edge sequences.
module tb_sr_bank;

  logic       clk;
  logic       rst_n;
  logic [7:0] s;
  logic [7:0] r;
  logic       clr_err;
  logic [7:0] e_s;
  logic [7:0] e_r;

  logic [7:0] q_w    [4];
  logic [7:0] qb_w   [4];
  logic [7:0] conf_w [4];
  logic [7:0] st_w   [4];
  logic [3:0] cnt_w  [4];

  logic [7:0] e_q;
  logic [7:0] e_qb;
  logic [7:0] e_conf;
  logic [7:0] e_st;
  logic [3:0] e_cnt;

  int n_chk;
  int n_err;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  for (genvar m = 0; m < 4; m++) begin : g_mode
    sr_bank #(
      .WIDTH(8), .CONFLICT_MODE(m), .RESET_VALUE(8'hA5), .EDGE_MODE(0), .CNT_W(4)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr_err(clr_err),
      .q(q_w[m]), .q_bar(qb_w[m]), .conflict(conf_w[m]),
`ifdef SR_BANK_CONFLICT_CNT_EN
      .conflict_cnt(cnt_w[m]),
`endif
      .err_sticky(st_w[m])
    );
`ifndef SR_BANK_CONFLICT_CNT_EN
    assign cnt_w[m] = 4'd0;
`endif
  end

  sr_bank #(
    .WIDTH(8), .CONFLICT_MODE(0), .RESET_VALUE(8'h00), .EDGE_MODE(1), .CNT_W(4)
  ) u_edge (
    .clk(clk), .rst_n(rst_n), .s(e_s), .r(e_r), .clr_err(clr_err),
    .q(e_q), .q_bar(e_qb), .conflict(e_conf),
`ifdef SR_BANK_CONFLICT_CNT_EN
    .conflict_cnt(e_cnt),
`endif
    .err_sticky(e_st)
  );
`ifndef SR_BANK_CONFLICT_CNT_EN
  assign e_cnt = 4'd0;
`endif

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_modes(input string tag, input logic [7:0] eq [4],
                               input logic [7:0] econf, input logic [7:0] est);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("%s q[m%0d]", tag, m), q_w[m], eq[m]);
      chk($sformatf("%s q_bar[m%0d]", tag, m), qb_w[m], ~eq[m]);
      chk($sformatf("%s conflict[m%0d]", tag, m), conf_w[m], econf);
      chk($sformatf("%s err_sticky[m%0d]", tag, m), st_w[m], est);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] s;
    logic [7:0] r;
    logic       clr;
    logic [7:0] q0, q1, q2, q3;
    logic [7:0] conf;
    logic [7:0] st;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs [16];

  // Scoreboard: {q0,q1,q2,q3,conf,st,cnt} pushed at drive, popped after edge.
  logic [51:0] exp_q [$];

  initial begin
    logic [7:0]  eq [4];
    logic [51:0] e;

    n_chk   = 0;
    n_err   = 0;
    s       = '0;
    r       = '0;
    clr_err = 1'b0;
    e_s     = '0;
    e_r     = '0;
    rst_n   = 1'b0;

    //           s      r      clr   q0     q1     q2     q3     conf   st     cnt
    vecs[0]  = '{8'h00, 8'h00, 1'b0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 4'd0};
    vecs[1]  = '{8'h00, 8'h00, 1'b0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 4'd0};
    vecs[2]  = '{8'h00, 8'h00, 1'b0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 4'd0};
    vecs[3]  = '{8'h00, 8'hFF, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0};
    vecs[4]  = '{8'h0F, 8'h00, 1'b0, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h00, 8'h00, 4'd0};
    vecs[5]  = '{8'h00, 8'h03, 1'b0, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h00, 8'h00, 4'd0};
    vecs[6]  = '{8'h03, 8'h00, 1'b0, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h00, 8'h00, 4'd0};
    vecs[7]  = '{8'hFF, 8'hFF, 1'b0, 8'h0F, 8'hFF, 8'h00, 8'hF0, 8'hFF, 8'hFF, 4'd8};
    vecs[8]  = '{8'h00, 8'h00, 1'b0, 8'h0F, 8'hFF, 8'h00, 8'hF0, 8'h00, 8'hFF, 4'd8};
    vecs[9]  = '{8'h00, 8'h00, 1'b1, 8'h0F, 8'hFF, 8'h00, 8'hF0, 8'h00, 8'h00, 4'd0};
    vecs[10] = '{8'h04, 8'h04, 1'b1, 8'h0F, 8'hFF, 8'h00, 8'hF4, 8'h04, 8'h04, 4'd1};
    vecs[11] = '{8'h00, 8'h00, 1'b0, 8'h0F, 8'hFF, 8'h00, 8'hF4, 8'h00, 8'h04, 4'd1};
    vecs[12] = '{8'h00, 8'h00, 1'b1, 8'h0F, 8'hFF, 8'h00, 8'hF4, 8'h00, 8'h00, 4'd0};
    vecs[13] = '{8'hA0, 8'h0A, 1'b0, 8'hA5, 8'hF5, 8'hA0, 8'hF4, 8'h00, 8'h00, 4'd0};
    vecs[14] = '{8'h3C, 8'hF0, 1'b0, 8'h2D, 8'h3D, 8'h0C, 8'h0C, 8'h30, 8'h30, 4'd2};
    vecs[15] = '{8'h00, 8'h00, 1'b0, 8'h2D, 8'h3D, 8'h0C, 8'h0C, 8'h00, 8'h30, 4'd2};

    // Reset, released mid-cycle; reset state visible before any edge.
    tick();
    tick();
    #3;
    rst_n = 1'b1;
    for (int m = 0; m < 4; m++) eq[m] = 8'hA5;
    chk_all_modes("reset", eq, 8'h00, 8'h00);
    chk("reset edge q", e_q, 8'h00);

    // Table-driven main sequence.
    for (int v = 0; v < 16; v++) begin
      s       = vecs[v].s;
      r       = vecs[v].r;
      clr_err = vecs[v].clr;
      exp_q.push_back({vecs[v].q0, vecs[v].q1, vecs[v].q2, vecs[v].q3,
                       vecs[v].conf, vecs[v].st, vecs[v].cnt});
      tick();
      e = exp_q.pop_front();
      eq[0] = e[51:44];
      eq[1] = e[43:36];
      eq[2] = e[35:28];
      eq[3] = e[27:20];
      chk_all_modes($sformatf("vec%0d", v), eq, e[19:12], e[11:4]);
`ifdef SR_BANK_CONFLICT_CNT_EN
      chk($sformatf("vec%0d conflict_cnt", v), {4'd0, cnt_w[0]}, {4'd0, e[3:0]});
`endif
    end
    s       = '0;
    r       = '0;
    clr_err = 1'b0;

    // Edge mode: s[0] held 4 clocks, r[0] pulsed in clock 3.
    e_s = 8'h01;
    tick();
    chk("edge clk1 q", e_q, 8'h01);
    tick();
    chk("edge clk2 q", e_q, 8'h01);
    e_r = 8'h01;
    tick();
    chk("edge clk3 q", e_q, 8'h00);
    e_r = 8'h00;
    tick();
    chk("edge clk4 q (level s ignored)", e_q, 8'h00);
    chk("edge conflict", e_conf, 8'h00);
    e_s = 8'h00;
    tick();
    // Simultaneous rising edges on channel 1 are a conflict; hold keeps 0.
    e_s = 8'h02;
    e_r = 8'h02;
    tick();
    chk("edge both q", e_q, 8'h00);
    chk("edge both conflict", e_conf, 8'h02);
    tick();
    chk("edge both held conflict", e_conf, 8'h00);
    chk("edge sticky", e_st, 8'h02);
    e_s = 8'h00;
    e_r = 8'h00;

`ifdef SR_BANK_CONFLICT_CNT_EN
    // Counter saturation: clear, then 20 single-channel conflicts.
    clr_err = 1'b1;
    tick();
    chk("cnt clear", {4'd0, cnt_w[0]}, 8'd0);
    clr_err = 1'b0;
    s = 8'h01;
    r = 8'h01;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("cnt sat k=%0d", k), {4'd0, cnt_w[0]}, (k > 15) ? 8'd15 : 8'(k));
    end
    s = '0;
    r = '0;
`endif

    // Async reset between edges with q=FF and conflict pulses live.
    s = 8'hFF;
    r = 8'h00;
    tick();
    chk("pre-reset q m0", q_w[0], 8'hFF);
    r = 8'hFF;
    e_s = 8'h01;
    tick();
    chk("pre-reset q m0 held", q_w[0], 8'hFF);
    chk("pre-reset conflict m0", conf_w[0], 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 4; m++) eq[m] = 8'hA5;
    chk_all_modes("async reset", eq, 8'h00, 8'h00);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("async reset cnt[m%0d]", m), {4'd0, cnt_w[m]}, 8'd0);
    end
    chk("async reset edge q", e_q, 8'h00);

    // s[0] high on the edge instance across reset release counts as an edge.
    s = '0;
    r = '0;
    tick();
    #3;
    rst_n = 1'b1;
    tick();
    chk("edge s high at release q", e_q, 8'h01);
    chk("post-release q m0", q_w[0], 8'hA5);
    e_s = '0;
    tick();

    if (exp_q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
